// File: rtl/output_conditioner.sv
// Drives a registered line level with a guaranteed minimum hold and queues one pending request.
// Optional bounce emulation for exercising remote debouncers: define OUTPUT_CONDITIONER_BOUNCE_EN.
module output_conditioner #(
   parameter int holdtime    = 3,
   parameter int bouncecount = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic positiveedge,
   input  logic negativeedge,
   input  logic faultactive,
   output logic pin,
   output logic conditioned,
   output logic busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BOUNCE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   localparam logic [7:0] HoldLast = 8'(holdtime - 1);

   if (holdtime < 1 || holdtime > 255) begin : gBadHoldtime
      $error("output_conditioner: holdtime out of range 1..255");
   end
   if (bouncecount < 1 || bouncecount > 15) begin : gBadBouncecount
      $error("output_conditioner: bouncecount out of range 1..15");
   end

   logic [1:0] state_q, state_d;
   logic [7:0] holdCnt_q, holdCnt_d;
   logic       pin_q, pin_d;
   logic       cond_q, cond_d;
   logic       pendValid_q, pendValid_d;
   logic       pendLevel_q, pendLevel_d;

`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
   localparam logic [4:0] BounceLast = 5'(2 * bouncecount - 1);
   logic [4:0] bounceCnt_q, bounceCnt_d;
   logic       target_q, target_d;
`endif

   logic reqValid;
   logic reqLevel;
   logic effPendValid;
   logic effPendLevel;
   logic startReq;
   logic startLevel;

   // Opposite requests in the same cycle cancel; a request seen on the HOLD exit cycle wins over the stored one.
   assign reqValid     = positiveedge ^ negativeedge;
   assign reqLevel     = positiveedge;
   assign effPendValid = pendValid_q | reqValid;
   assign effPendLevel = reqValid ? reqLevel : pendLevel_q;

   always_comb begin
      state_d     = state_q;
      holdCnt_d   = holdCnt_q;
      pin_d       = pin_q;
      cond_d      = cond_q;
      pendValid_d = pendValid_q;
      pendLevel_d = pendLevel_q;
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
      bounceCnt_d = bounceCnt_q;
      target_d    = target_q;
`endif
      startReq    = 1'b0;
      startLevel  = reqLevel;

      case (state_q)
         IDLE: begin
            if (reqValid && (reqLevel != cond_q)) begin
               startReq   = 1'b1;
               startLevel = reqLevel;
            end
         end
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
         BOUNCE: begin
            if (reqValid) begin
               pendValid_d = 1'b1;
               pendLevel_d = reqLevel;
            end
            if (bounceCnt_q == BounceLast) begin
               state_d   = HOLD;
               pin_d     = target_q;
               cond_d    = target_q;
               holdCnt_d = 8'd0;
            end else begin
               bounceCnt_d = bounceCnt_q + 5'd1;
               // Even bounce steps show the new level, odd steps the old one.
               pin_d       = bounceCnt_q[0] ? target_q : ~target_q;
            end
         end
`endif
         HOLD: begin
            if (holdCnt_q == HoldLast) begin
               pendValid_d = 1'b0;
               if (effPendValid && (effPendLevel != cond_q)) begin
                  startReq   = 1'b1;
                  startLevel = effPendLevel;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               holdCnt_d = holdCnt_q + 8'd1;
               if (reqValid) begin
                  pendValid_d = 1'b1;
                  pendLevel_d = reqLevel;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (startReq) begin
         pin_d = startLevel;
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
         state_d     = BOUNCE;
         bounceCnt_d = 5'd0;
         target_d    = startLevel;
`else
         state_d   = HOLD;
         cond_d    = startLevel;
         holdCnt_d = 8'd0;
`endif
      end
   end

   // A fault freezes everything, including pending capture; reset overrides the freeze.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         holdCnt_q   <= 8'd0;
         pin_q       <= 1'b0;
         cond_q      <= 1'b0;
         pendValid_q <= 1'b0;
         pendLevel_q <= 1'b0;
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
         bounceCnt_q <= 5'd0;
         target_q    <= 1'b0;
`endif
      end else if (!faultactive) begin
         state_q     <= state_d;
         holdCnt_q   <= holdCnt_d;
         pin_q       <= pin_d;
         cond_q      <= cond_d;
         pendValid_q <= pendValid_d;
         pendLevel_q <= pendLevel_d;
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
         bounceCnt_q <= bounceCnt_d;
         target_q    <= target_d;
`endif
      end
   end

   assign pin         = pin_q;
   assign conditioned = cond_q;
   assign busy        = (state_q == BOUNCE) || (state_q == HOLD);

endmodule

// File: tb/tb_output_conditioner.sv
// Randomized bench for output_conditioner: a queue-based plan model checked every cycle, plus literal sequences.
module tb_output_conditioner;

   localparam int HT = 3;
   localparam int BC = 2;

   logic clk          = 1'b0;
   logic reset        = 1'b0;
   logic positiveedge = 1'b0;
   logic negativeedge = 1'b0;
   logic faultactive  = 1'b0;
   logic pin, conditioned, busy;

   int assertCount = 0;
   int failCount   = 0;

   output_conditioner #(.holdtime(HT), .bouncecount(BC)) dut (
      .clk(clk),
      .reset(reset),
      .positiveedge(positiveedge),
      .negativeedge(negativeedge),
      .faultactive(faultactive),
      .pin(pin),
      .conditioned(conditioned),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: a transition is a list of (pin, conditioned) values, one per busy cycle.
   typedef struct packed {
      logic p;
      logic c;
   } step_t;

   step_t plan[$];
   logic  mPin = 1'b0, mCond = 1'b0, mBusy = 1'b0, mValid = 1'b0;
   logic  mPendValid = 1'b0, mPendLevel = 1'b0;

   task automatic popStep();
      step_t s;
      s     = plan.pop_front();
      mPin  = s.p;
      mCond = s.c;
   endtask

   task automatic modelStart(input logic lvl);
      plan.delete();
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
      for (int i = 0; i < 2 * BC; i++) plan.push_back('{p: ((i % 2) == 0) ? lvl : ~lvl, c: mCond});
`endif
      for (int i = 0; i < HT; i++) plan.push_back('{p: lvl, c: lvl});
      popStep();
      mBusy = 1'b1;
   endtask

   always @(posedge clk) begin
      logic req, lvl;
      req = positiveedge ^ negativeedge;
      lvl = positiveedge;
      if (reset) begin
         mPin = 1'b0; mCond = 1'b0; mBusy = 1'b0; mPendValid = 1'b0;
         plan.delete();
         mValid = 1'b1;
      end else if (!faultactive) begin
         if (!mBusy) begin
            if (req && lvl != mCond) modelStart(lvl);
         end else begin
            if (req) begin
               mPendValid = 1'b1;
               mPendLevel = lvl;
            end
            if (plan.size() == 0) begin
               if (mPendValid && mPendLevel != mCond) modelStart(mPendLevel);
               else mBusy = 1'b0;
               mPendValid = 1'b0;
            end else begin
               popStep();
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic act, input logic exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("model.pin", pin, mPin);
         checkOutput("model.conditioned", conditioned, mCond);
         checkOutput("model.busy", busy, mBusy);
      end
   end

   task automatic applyStimulus(input logic r, input logic p, input logic n, input logic f);
      reset        = r;
      positiveedge = p;
      negativeedge = n;
      faultactive  = f;
      @(negedge clk);
   endtask

   task automatic expectState(input string name, input logic p, input logic c, input logic b);
      checkOutput({name, ".pin"}, pin, p);
      checkOutput({name, ".conditioned"}, conditioned, c);
      checkOutput({name, ".busy"}, busy, b);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0); expectState("reset", 0, 0, 0);
      applyStimulus(0, 0, 0, 0); expectState("idle", 0, 0, 0);
`ifdef OUTPUT_CONDITIONER_BOUNCE_EN
      applyStimulus(0, 1, 0, 0); expectState("bounce0", 1, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("bounce1", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("bounce2", 1, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("bounce3", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("bhold0", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("bhold1", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("bhold2", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("bexit", 1, 1, 0);
`else
      applyStimulus(0, 1, 0, 0); expectState("accept", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("hold1", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("hold2", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("holdexit", 1, 1, 0);
      applyStimulus(0, 1, 0, 0); expectState("samelevel", 1, 1, 0);
      applyStimulus(0, 1, 1, 0); expectState("bothreq", 1, 1, 0);
      applyStimulus(0, 0, 1, 0); expectState("fall", 0, 0, 1);
      applyStimulus(0, 1, 0, 0); expectState("queued", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("queuedhold", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("chain", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("chainhold1", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("chainhold2", 1, 1, 1);
      applyStimulus(0, 0, 0, 0); expectState("chainexit", 1, 1, 0);
      applyStimulus(0, 0, 1, 0); expectState("fall2", 0, 0, 1);
      applyStimulus(0, 0, 0, 1); expectState("frozen1", 0, 0, 1);
      applyStimulus(0, 1, 0, 1); expectState("frozen2", 0, 0, 1);
      applyStimulus(0, 0, 0, 1); expectState("frozen3", 0, 0, 1);
      applyStimulus(0, 0, 0, 1); expectState("frozen4", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("thaw1", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("thaw2", 0, 0, 1);
      applyStimulus(0, 0, 0, 0); expectState("freezeexit", 0, 0, 0);
      applyStimulus(0, 1, 0, 0); expectState("rise", 1, 1, 1);
      applyStimulus(1, 0, 0, 0); expectState("midreset", 0, 0, 0);
      applyStimulus(0, 0, 1, 0); expectState("afterreset", 0, 0, 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(99) == 0),
                       ($urandom_range(3) == 0),
                       ($urandom_range(3) == 0),
                       ($urandom_range(9) == 0));
      end
      applyStimulus(0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
